instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder: the inverse of the pipeline's instruction decoder. It accepts decoded fields (format, opcode, register addresses, funct3/funct7, full-width immediate) over a valid/ready stream and packs them into 32-bit instruction words. Encoded words are buffered and emitted with an auto-incrementing byte address. It sits in front of instruction memory as the program loader and self-test generator, and in the verification environment as a reference encoder.

## Interface
- `DATAW`, 32, instruction/immediate width
- `ADDRW`, 5, register address width
- `IMEM_ADDRW`, 12, byte address width of `out_addr`
- `FIFO_DEPTH`, 4, output buffer entries (power of 2, ≥2)

- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `in_valid` in 1: field bundle valid
- `in_ready` out 1: encoder can accept
- `in_fmt` in 3: format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 I_SHIFT, 7 reserved
- `in_opcode` in 7: opcode[6:0]
- `in_rd`, `in_rs1`, `in_rs2` in ADDRW each: register addresses
- `in_funct3` in 3, `in_funct7` in 7: function fields
- `in_imm` in DATAW: immediate as a signed byte value, unshifted
- `addr_load` in 1: load `base_addr` into the address counter
- `base_addr` in IMEM_ADDRW: load value
- `out_valid` out 1: encoded word available
- `out_ready` in 1: consumer accepts
- `out_instr` out DATAW: encoded instruction
- `out_addr` out IMEM_ADDRW: byte address of `out_instr`
- `err_imm` out 1: sticky immediate range error
- `err_fmt` out 1: sticky reserved-format error

## Operation
- Accept when `in_valid & in_ready`. Encode combinationally, then push into the FIFO in the same cycle.
- Field packing (fields not listed are zero):
  - opcode [6:0]; rd [11:7] for R/I/I_SHIFT/U/J; funct3 [14:12] for R/I/I_SHIFT/S/B; rs1 [19:15] for R/I/I_SHIFT/S/B; rs2 [24:20] for R/S/B; funct7 [31:25] for R/I_SHIFT.
  - I: [31:20]=imm[11:0].
  - I_SHIFT: [24:20]=imm[4:0], [31:25]=funct7.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Reserved format (7): the bundle is consumed, nothing is pushed, and `err_fmt` sets.
- Pop when `out_valid & out_ready`. `out_addr` then increments by 4 and wraps modulo 2^IMEM_ADDRW.
- `addr_load` loads `base_addr` and overrides an increment in the same cycle. A word popped in that cycle carries the pre-load address.
- Error flags clear only on reset.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0, and 1 in the first cycle after release. `out_valid`=0, `out_addr`=0, `err_imm`=0, `err_fmt`=0, FIFO count=0.
- Latency: a word accepted in cycle N is presented with `out_valid`=1 in N+1 at the earliest. There is no same-cycle bypass.
- `in_ready` = (count < FIFO_DEPTH), derived from the registered count.
  - When full, `in_ready`=0 even if a pop occurs that cycle; it rises the cycle after the pop.
  - When not full, a simultaneous push and pop leave count unchanged.
- `out_instr`/`out_addr` stay stable while `out_valid & ~out_ready`.
- Asserting `rst_n`=0 mid-stream flushes the FIFO and discards in-flight words, including the one being accepted.

## Configuration
- `ENCODER_RANGE_CHECK_EN` defined: immediates are range-checked. A failing bundle is consumed but not pushed, and `err_imm` sets. Rules:
  - I/S: in_imm equals sign-extension of imm[11:0].
  - B: 13-bit signed and imm[0]=0.
  - J: 21-bit signed and imm[0]=0.
  - U: imm[11:0]=0.
  - I_SHIFT: imm[31:5]=0.
- Undefined: immediates are truncated silently and `err_imm` is tied to 0.

## Structure
- Package `enc_pkg`: format enum, RV32I opcode constants, immediate width constants (12, 13, 20, 21).
- Sub-module `sync_fifo`: parameterized width/depth, registered count, full/empty flags.
- Encoder and range check are combinational logic in `instr_encoder`.

## Test plan
- ADDI: fmt I, opcode 0x13, rd 1, rs1 0, funct3 0, imm 5 -> `out_instr` 0x00500093 at `out_addr` 0, one cycle after accept.
- R/S stream: ADD x3,x1,x2 (0x33, f3 0, f7 0) then SW x2,8(x1) (0x23, f3 2) -> 0x002081B3 @0, 0x0020A423 @4.
- Branch/U/shift: BEQ x0,x0,-4 -> 0xFE000EE3; LUI x5, imm 0x12345000 -> 0x123452B7; I_SHIFT SRAI x1,x1,3 (f3 5, f7 0x20) -> 0x4030D093.
- Backpressure: `out_ready`=0 with 4 pushes -> `in_ready`=0 after the 4th; one pop -> `in_ready`=1 the next cycle; drained addresses 0,4,8,12 in order.
- Errors (macro on): I-type imm 2048 -> no `out_valid`, `err_imm`=1 and stays set; fmt 7 -> `err_fmt`=1. Macro off: same I-type -> 0x80000093-style truncated word, `err_imm`=0.
- `addr_load` with `base_addr`=0x100 while popping -> popped word keeps its old address, next word at 0x100; reset mid-stream -> `out_valid`=0, count=0.

Source files
------------

// File: rtl/enc_pkg.sv
// ============================================================================
// Module   : enc_pkg
// Brief    : Shared RV32I encoder types, opcodes and immediate widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_I_SHIFT = 3'd6,
      FMT_RSV     = 3'd7
   } fmt_e;

   localparam logic [6:0] c_op_lui    = 7'h37;
   localparam logic [6:0] c_op_auipc  = 7'h17;
   localparam logic [6:0] c_op_jal    = 7'h6F;
   localparam logic [6:0] c_op_jalr   = 7'h67;
   localparam logic [6:0] c_op_branch = 7'h63;
   localparam logic [6:0] c_op_load   = 7'h03;
   localparam logic [6:0] c_op_store  = 7'h23;
   localparam logic [6:0] c_op_imm    = 7'h13;
   localparam logic [6:0] c_op_reg    = 7'h33;

   localparam int unsigned c_imm_i_w = 12;
   localparam int unsigned c_imm_b_w = 13;
   localparam int unsigned c_imm_u_w = 20;
   localparam int unsigned c_imm_j_w = 21;

   // True when v is the sign extension of its low w bits (bits [31:w-1] all equal).
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << (w - 1);
      return ((v & m) == 32'd0) || ((v & m) == m);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Synchronous FIFO with registered occupancy count, full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == c_cnt_w'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs decoded RV32I fields into instruction words with addresses.
// Macros   : ENCODER_RANGE_CHECK_EN enables immediate range checking/err_imm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
   import enc_pkg::*;
#(
   parameter int DATAW      = 32,
   parameter int ADDRW      = 5,
   parameter int IMEM_ADDRW = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_fmt,
   input  logic [6:0]            in_opcode,
   input  logic [ADDRW-1:0]      in_rd,
   input  logic [ADDRW-1:0]      in_rs1,
   input  logic [ADDRW-1:0]      in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [DATAW-1:0]      in_imm,
   input  logic                  addr_load,
   input  logic [IMEM_ADDRW-1:0] base_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATAW-1:0]      out_instr,
   output logic [IMEM_ADDRW-1:0] out_addr,
   output logic                  err_imm,
   output logic                  err_fmt
);

   fmt_e                  w_fmt;
   logic [DATAW-1:0]      w_instr;
   logic                  w_imm_ok;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  r_err_fmt;
   logic [IMEM_ADDRW-1:0] r_addr;

   assign w_fmt    = fmt_e'(in_fmt);
   assign in_ready = rst_n & ~w_full;
   assign w_accept = in_valid & in_ready;
   assign w_push   = w_accept & (w_fmt != FMT_RSV) & w_imm_ok;
   assign out_valid = ~w_empty;
   assign w_pop    = out_valid & out_ready;
   assign out_addr = r_addr;
   assign err_fmt  = r_err_fmt;

   always_comb begin
      w_instr = '0;
      case (w_fmt)
         FMT_R:       w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I:       w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I_SHIFT: w_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S:       w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B:       w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
         FMT_U:       w_instr = {in_imm[31:12], in_rd, in_opcode};
         FMT_J:       w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
         default:     w_instr = '0;
      endcase
   end

`ifdef ENCODER_RANGE_CHECK_EN
   logic r_err_imm;

   always_comb begin
      w_imm_ok = 1'b1;
      case (w_fmt)
         FMT_I, FMT_S: w_imm_ok = fits_signed(in_imm, c_imm_i_w);
         FMT_B:        w_imm_ok = fits_signed(in_imm, c_imm_b_w) & ~in_imm[0];
         FMT_J:        w_imm_ok = fits_signed(in_imm, c_imm_j_w) & ~in_imm[0];
         FMT_U:        w_imm_ok = (in_imm[DATAW-c_imm_u_w-1:0] == '0);
         FMT_I_SHIFT:  w_imm_ok = (in_imm[DATAW-1:5] == '0);
         default:      w_imm_ok = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_imm <= 1'b0;
      end else if (w_accept & (w_fmt != FMT_RSV) & ~w_imm_ok) begin
         r_err_imm <= 1'b1;
      end
   end

   assign err_imm = r_err_imm;
`else
   assign w_imm_ok = 1'b1;
   assign err_imm  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_fmt <= 1'b0;
      end else if (w_accept & (w_fmt == FMT_RSV)) begin
         r_err_fmt <= 1'b1;
      end
   end

   // A load wins over the pop increment; the popped word already saw the old address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr <= '0;
      end else if (addr_load) begin
         r_addr <= base_addr;
      end else if (w_pop) begin
         r_addr <= r_addr + IMEM_ADDRW'(4);
      end
   end

   sync_fifo #(
      .WIDTH (DATAW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_instr),
      .i_pop   (w_pop),
      .o_data  (out_instr),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed self-checking bench for instr_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_fmt = '0;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        addr_load = 1'b0;
   logic [11:0] base_addr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [11:0] out_addr;
   logic        err_imm;
   logic        err_fmt;

   int total = 0;
   int bad   = 0;

   instr_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .addr_load (addr_load),
      .base_addr (base_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .err_imm   (err_imm),
      .err_fmt   (err_fmt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
   endtask

   task automatic push(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, output bit ok);
      drive(f, op, rd, rs1, rs2, f3, f7, imm);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_addi(input logic [4:0] rd, output bit ok);
      push(3'd1, 7'h13, rd, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, ok);
   endtask

   task automatic pop(output bit ok, output logic [31:0] ins, output logic [11:0] ad);
      out_ready = 1'b1;
      ok = 1'b0; ins = '0; ad = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; ins = out_instr; ad = out_addr; break; end
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (out_addr !== 12'h000) begin bad++; $display("FAIL rst_out_addr got=%h exp=000", out_addr); end
      total++; if ({err_imm, err_fmt} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {err_imm, err_fmt}); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
      total++; if (dut.u_fifo.r_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", dut.u_fifo.r_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_addi_latency();
      do_reset();
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      in_valid = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_no_bypass got=%b exp=0", out_valid); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
      total++; if (out_instr !== 32'h00500093) begin bad++; $display("FAIL addi_instr got=%h exp=00500093", out_instr); end
      total++; if (out_addr !== 12'h000) begin bad++; $display("FAIL addi_addr got=%h exp=000", out_addr); end
   endtask

   task automatic test_rs_stream();
      bit ok; logic [31:0] ins; logic [11:0] ad;
      do_reset();
      push(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL add_push got=timeout exp=accept"); end
      push(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL sw_push got=timeout exp=accept"); end
      pop(ok, ins, ad);
      total++; if (!ok || ins !== 32'h002081B3 || ad !== 12'h000) begin bad++; $display("FAIL add_word got=%h@%h ok=%b exp=002081b3@000", ins, ad, ok); end
      pop(ok, ins, ad);
      total++; if (!ok || ins !== 32'h0020A423 || ad !== 12'h004) begin bad++; $display("FAIL sw_word got=%h@%h ok=%b exp=0020a423@004", ins, ad, ok); end
   endtask

   task automatic test_branch_u_shift_j();
      bit ok; logic [31:0] ins; logic [11:0] ad;
      do_reset();
      push(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, ok);
      push(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, ok);
      push(3'd6, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, ok);
      push(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, ok);
      pop(ok, ins, ad);
      total++; if (!ok || ins !== 32'hFE000EE3 || ad !== 12'h000) begin bad++; $display("FAIL beq_word got=%h@%h exp=fe000ee3@000", ins, ad); end
      pop(ok, ins, ad);
      total++; if (!ok || ins !== 32'h123452B7 || ad !== 12'h004) begin bad++; $display("FAIL lui_word got=%h@%h exp=123452b7@004", ins, ad); end
      pop(ok, ins, ad);
      total++; if (!ok || ins !== 32'h4030D093 || ad !== 12'h008) begin bad++; $display("FAIL srai_word got=%h@%h exp=4030d093@008", ins, ad); end
      pop(ok, ins, ad);
      total++; if (!ok || ins !== 32'h001000EF || ad !== 12'h00C) begin bad++; $display("FAIL jal_word got=%h@%h exp=001000ef@00c", ins, ad); end
   endtask

   task automatic test_backpressure();
      bit ok; logic [31:0] ins; logic [11:0] ad;
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h00500113; exp_w[1] = 32'h00500193; exp_w[2] = 32'h00500213; exp_w[3] = 32'h00500293;
      do_reset();
      for (int k = 1; k <= 4; k++) push_addi(5'(k), ok);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
      total++; if (dut.u_fifo.r_count !== 3'd4) begin bad++; $display("FAIL bp_full_count got=%0d exp=4", dut.u_fifo.r_count); end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle_ready got=%b exp=0", in_ready); end
      total++; if (out_instr !== 32'h00500093 || out_addr !== 12'h000) begin bad++; $display("FAIL bp_head got=%h@%h exp=00500093@000", out_instr, out_addr); end
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop_ready got=%b exp=1", in_ready); end
      // simultaneous push and pop while not full
      @(posedge clk); #1;
      drive(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      total++; if (dut.u_fifo.r_count !== 3'd3) begin bad++; $display("FAIL bp_push_pop_count got=%0d exp=3", dut.u_fifo.r_count); end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         pop(ok, ins, ad);
         total++;
         if (!ok || ins !== exp_w[k+1] || ad !== 12'(8 + 4*k)) begin
            bad++; $display("FAIL bp_drain%0d got=%h@%h exp=%h@%h", k, ins, ad, exp_w[k+1], 12'(8 + 4*k));
         end
      end
   endtask

   task automatic test_addr_load();
      bit ok; logic [31:0] ins; logic [11:0] ad;
      do_reset();
      push_addi(5'd1, ok);
      push_addi(5'd2, ok);
      out_ready = 1'b1; addr_load = 1'b1; base_addr = 12'h100;
      @(negedge clk);
      total++; if (out_addr !== 12'h000 || out_instr !== 32'h00500093) begin bad++; $display("FAIL load_pop_old got=%h@%h exp=00500093@000", out_instr, out_addr); end
      @(posedge clk); #1 out_ready = 1'b0; addr_load = 1'b0;
      @(negedge clk);
      total++; if (out_addr !== 12'h100 || out_instr !== 32'h00500113) begin bad++; $display("FAIL load_next got=%h@%h exp=00500113@100", out_instr, out_addr); end
      @(posedge clk); #1 addr_load = 1'b1; base_addr = 12'hFFC;
      @(posedge clk); #1 addr_load = 1'b0;
      push_addi(5'd3, ok);
      pop(ok, ins, ad);
      total++; if (!ok || ad !== 12'hFFC) begin bad++; $display("FAIL load_top got=%h exp=ffc", ad); end
      pop(ok, ins, ad);
      total++; if (!ok || ad !== 12'h000 || ins !== 32'h00500193) begin bad++; $display("FAIL addr_wrap got=%h@%h exp=00500193@000", ins, ad); end
   endtask

   task automatic test_errors();
      bit ok;
      do_reset();
      push(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL err_imm_accept got=timeout exp=accept"); end
      @(negedge clk);
`ifdef ENCODER_RANGE_CHECK_EN
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_imm_nopush got=%b exp=0", out_valid); end
      total++; if (err_imm !== 1'b1) begin bad++; $display("FAIL err_imm_set got=%b exp=1", err_imm); end
`else
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h80000093) begin bad++; $display("FAIL trunc_word got=%h v=%b exp=80000093", out_instr, out_valid); end
      total++; if (err_imm !== 1'b0) begin bad++; $display("FAIL err_imm_tied got=%b exp=0", err_imm); end
`endif
      @(posedge clk); #1;
      push(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ok);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (err_fmt !== 1'b1) begin bad++; $display("FAIL err_fmt_set got=%b exp=1", err_fmt); end
`ifdef ENCODER_RANGE_CHECK_EN
      total++; if (dut.u_fifo.r_count !== 3'd0) begin bad++; $display("FAIL err_fmt_count got=%0d exp=0", dut.u_fifo.r_count); end
      total++; if (err_imm !== 1'b1) begin bad++; $display("FAIL err_imm_sticky got=%b exp=1", err_imm); end
`else
      total++; if (dut.u_fifo.r_count !== 3'd1) begin bad++; $display("FAIL err_fmt_count got=%0d exp=1", dut.u_fifo.r_count); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      push_addi(5'd1, ok);
      push_addi(5'd2, ok);
      drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      in_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
      @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
      total++; if (dut.u_fifo.r_count !== 3'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", dut.u_fifo.r_count); end
      total++; if (err_fmt !== 1'b0 || out_addr !== 12'h000) begin bad++; $display("FAIL mid_rst_state got=%b/%h exp=0/000", err_fmt, out_addr); end
   endtask

   initial begin
      test_reset();
      test_addi_latency();
      test_rs_stream();
      test_branch_u_shift_j();
      test_backpressure();
      test_addr_load();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
